// File: rtl/issuer_pkg.sv
// Shared types and instruction field layout for the instruction issuer.
package issuer_pkg;

  localparam int unsigned INST_W   = 16;
  localparam int unsigned RX_HI    = 15;
  localparam int unsigned RX_LO    = 13;
  localparam int unsigned RY_HI    = 12;
  localparam int unsigned RY_LO    = 10;
  localparam int unsigned OP_HI    = 4;
  localparam int unsigned OP_LO    = 2;
  localparam int unsigned LAST_BIT = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StIssue,
    StRetire,
    StErr
  } issuer_state_t;

  typedef struct packed {
    logic [2:0] rx;
    logic [2:0] ry;
    logic [2:0] op;
    logic       last;
  } inst_fields_t;

  function automatic inst_fields_t inst_decode(input logic [INST_W-1:0] inst);
    inst_fields_t f;
    f.rx   = inst[RX_HI:RX_LO];
    f.ry   = inst[RY_HI:RY_LO];
    f.op   = inst[OP_HI:OP_LO];
    f.last = inst[LAST_BIT];
    return f;
  endfunction

  function automatic logic inst_is_last(input logic [INST_W-1:0] inst);
    return inst[LAST_BIT];
  endfunction

endpackage

// File: rtl/inst_issuer_if.sv
// Program-memory read port plus the run/d_inst/done handshake towards the CPU.
interface inst_issuer_if #(
  parameter int unsigned ADDR_W = 4
);
  import issuer_pkg::*;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [INST_W-1:0] mem_rdata;
  logic              run;
  logic [INST_W-1:0] d_inst;
  logic              done;

  modport master (
    output mem_en,
    output mem_addr,
    input  mem_rdata,
    output run,
    output d_inst,
    input  done
  );

  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_rdata,
    input  run,
    input  d_inst,
    output done
  );

endinterface

// File: rtl/issue_watchdog.sv
// Counts ISSUE cycles without done; expired flags the last permitted cycle.
module issue_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_q, count_d;

  assign expired = (count_q == 8'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/inst_issuer.sv
// Fetches instructions from a synchronous program memory and hands each one to
// the CPU over run/d_inst/done, retiring on done and halting on LAST or end of memory.
module inst_issuer
  import issuer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  inst_issuer_if.master   bus,
  output logic            busy,
  output logic            finished,
  output logic            err_timeout,
  output logic [ADDR_W:0] inst_count
);

  localparam logic [ADDR_W-1:0] PcLast = '1;
  localparam logic [ADDR_W:0]   CntMax = {1'b1, {ADDR_W{1'b0}}};

  issuer_state_t     state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wd_expired;
  logic              last_inst;
  logic              launch;

  assign last_inst = inst_is_last(ir_q) || (pc_q == PcLast);
  assign launch    = ((state_q == StIdle) || (state_q == StErr)) && start;

  issue_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == StLoad),
    .enable  ((state_q == StIssue) && !bus.done),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StErr: if (start) state_d = StFetch;
      StFetch:       state_d = StLoad;
      StLoad:        state_d = StIssue;
      // done takes priority over a watchdog expiring in the same cycle
      StIssue: begin
        if (bus.done) begin
          state_d = StRetire;
        end else if (wd_expired) begin
          state_d = StErr;
        end
      end
      StRetire:      state_d = last_inst ? StIdle : StFetch;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.mem_en  = 1'b0;
    bus.run     = 1'b0;
    busy        = 1'b1;
    finished    = 1'b0;
    err_timeout = 1'b0;
    unique case (state_q)
      StIdle:   busy = 1'b0;
      StFetch:  bus.mem_en = 1'b1;
      StLoad:   ;
      StIssue:  bus.run = 1'b1;
      StRetire: finished = last_inst;
      StErr: begin
        busy        = 1'b0;
        err_timeout = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

  assign bus.mem_addr = pc_q;
  assign bus.d_inst   = ir_q;
  assign inst_count   = cnt_q;

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    cnt_d = cnt_q;
    if (launch) begin
      pc_d  = '0;
      cnt_d = '0;
    end
    if (state_q == StLoad) begin
      ir_d = bus.mem_rdata;
    end
    if (state_q == StRetire) begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (!last_inst) begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_issuer.sv
// Bench for inst_issuer: program ROM model, CPU model finishing on its third run cycle.
module tb_inst_issuer;
  import issuer_pkg::*;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            busy;
  logic            finished;
  logic            err_timeout;
  logic [ADDR_W:0] inst_count;

  inst_issuer_if #(.ADDR_W(ADDR_W)) bus ();

  inst_issuer #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .finished    (finished),
    .err_timeout (err_timeout),
    .inst_count  (inst_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  logic [15:0] rdata = '0;
  always @(posedge clk) if (bus.mem_en) rdata <= mem[bus.mem_addr];
  assign bus.mem_rdata = rdata;

  int   run_cyc = 0;
  logic cpu_en, done_force;
  always @(posedge clk) run_cyc <= bus.run ? run_cyc + 1 : 0;
  assign bus.done = (cpu_en && bus.run && run_cyc == 2) || done_force;

  logic [15:0]       exp_q[$];
  logic [15:0]       obs_inst[$];
  logic [ADDR_W-1:0] obs_addr[$];
  int                obs_len[$];
  int                obs_gap[$];
  int fin_k, fin_n, end_k, unstable;
  logic err_first;
  bit   timed_out;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [15:0] got;

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records what the DUT does from the cycle after the start edge (k=1) until busy drops.
  task automatic observe(input int budget, input int start_at);
    int k, len, gap;
    logic prev_run;
    logic [15:0] held;
    bit seen;
    obs_inst.delete(); obs_addr.delete(); obs_len.delete(); obs_gap.delete();
    fin_k = 0; fin_n = 0; end_k = 0; unstable = 0;
    k = 1; len = 0; gap = 0; seen = 0; prev_run = 1'b0; held = '0;
    timed_out = 1; err_first = err_timeout;
    while (k <= budget) begin
      if (bus.mem_en) obs_addr.push_back(bus.mem_addr);
      if (bus.run) begin
        if (!prev_run) begin
          obs_inst.push_back(bus.d_inst);
          held = bus.d_inst;
          if (seen) obs_gap.push_back(gap);
          len = 0;
          seen = 1;
        end else if (bus.d_inst !== held) begin
          unstable++;
        end
        len++;
      end else begin
        if (prev_run) begin
          obs_len.push_back(len);
          gap = 0;
        end
        gap++;
      end
      prev_run = bus.run;
      if (finished) begin
        fin_k = k;
        fin_n++;
      end
      if (!busy) begin
        end_k = k;
        timed_out = 0;
        break;
      end
      start = (k == start_at);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; cpu_en = 1'b1; done_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({bus.mem_en, bus.run, busy, finished, err_timeout} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000",
                        {bus.mem_en, bus.run, busy, finished, err_timeout});
    end
    n_vec++; if (bus.d_inst !== 16'h0) begin
      n_bad++; $display("FAIL reset_d_inst: got %h want 0000", bus.d_inst);
    end
    n_vec++; if ({bus.mem_addr, inst_count} !== '0) begin
      n_bad++; $display("FAIL reset_addr_cnt: got %h/%h want 0/0", bus.mem_addr, inst_count);
    end
    #3 reset = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: busy got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    mem[0] = 16'h2405;
    exp_q.push_back(16'h2405);
    do_start();
    observe(40, 0);
    n_vec++; if (timed_out) begin n_bad++; $display("FAIL single_timeout: got 1 want 0"); end
    while (exp_q.size() > 0) begin
      got = (obs_inst.size() > 0) ? obs_inst.pop_front() : 16'hxxxx;
      n_vec++; if (got !== exp_q[0]) begin
        n_bad++; $display("FAIL single_inst: got %h want %h", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_vec++; if (obs_len.size() != 1 || obs_len[0] != 3) begin
      n_bad++; $display("FAIL single_runlen: got %p want '{3}", obs_len);
    end
    n_vec++; if (fin_k != 6 || fin_n != 1 || end_k != 7) begin
      n_bad++; $display("FAIL single_finish: got k=%0d n=%0d end=%0d want 6/1/7",
                        fin_k, fin_n, end_k);
    end
    n_vec++; if (inst_count !== 5'd1) begin
      n_bad++; $display("FAIL single_count: got %0d want 1", inst_count);
    end
    n_vec++; if (bus.d_inst !== 16'h2405) begin
      n_bad++; $display("FAIL single_hold: got %h want 2405", bus.d_inst);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    prog[0] = 16'h2004; prog[1] = 16'h4408; prog[2] = 16'h6C01;
    for (int i = 0; i < 3; i++) begin
      mem[i] = prog[i];
      exp_q.push_back(prog[i]);
    end
    do_start();
    observe(80, 0);
    n_vec++; if (timed_out) begin n_bad++; $display("FAIL b2b_timeout: got 1 want 0"); end
    while (exp_q.size() > 0) begin
      got = (obs_inst.size() > 0) ? obs_inst.pop_front() : 16'hxxxx;
      n_vec++; if (got !== exp_q[0]) begin
        n_bad++; $display("FAIL b2b_inst: got %h want %h", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_vec++; if (obs_gap.size() != 2 || obs_gap[0] != 3 || obs_gap[1] != 3) begin
      n_bad++; $display("FAIL b2b_gaps: got %p want '{3,3}", obs_gap);
    end
    n_vec++; if (obs_addr.size() != 3 || obs_addr[0] != 0 || obs_addr[1] != 1
                 || obs_addr[2] != 2) begin
      n_bad++; $display("FAIL b2b_addr: got %p want '{0,1,2}", obs_addr);
    end
    n_vec++; if (fin_k != 18 || fin_n != 1 || inst_count !== 5'd3 || unstable != 0) begin
      n_bad++; $display("FAIL b2b_finish: got k=%0d n=%0d cnt=%0d unst=%0d want 18/1/3/0",
                        fin_k, fin_n, inst_count, unstable);
    end
  endtask

  task automatic test_end_of_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'h1000 | 16'(i << 4);
      exp_q.push_back(mem[i]);
    end
    do_start();
    observe(200, 0);
    n_vec++; if (timed_out) begin n_bad++; $display("FAIL eom_timeout: got 1 want 0"); end
    while (exp_q.size() > 0) begin
      got = (obs_inst.size() > 0) ? obs_inst.pop_front() : 16'hxxxx;
      n_vec++; if (got !== exp_q[0]) begin
        n_bad++; $display("FAIL eom_inst: got %h want %h", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_vec++; if (obs_addr.size() != 16) begin
      n_bad++; $display("FAIL eom_fetches: got %0d want 16", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size(); i++) begin
      n_vec++; if (obs_addr[i] != ADDR_W'(i)) begin
        n_bad++; $display("FAIL eom_addr: got %0d want %0d", obs_addr[i], i);
      end
    end
    n_vec++; if (inst_count !== 5'd16 || fin_k != 96 || fin_n != 1) begin
      n_bad++; $display("FAIL eom_finish: got cnt=%0d k=%0d n=%0d want 16/96/1",
                        inst_count, fin_k, fin_n);
    end
    repeat (4) begin
      @(posedge clk); #1;
      n_vec++; if (bus.mem_en !== 1'b0 || busy !== 1'b0 || inst_count !== 5'd16) begin
        n_bad++; $display("FAIL eom_halt: got en=%b busy=%b cnt=%0d want 0/0/16",
                          bus.mem_en, busy, inst_count);
      end
    end
  endtask

  task automatic test_watchdog();
    mem[0] = 16'h2405;
    cpu_en = 1'b0;
    do_start();
    observe(60, 0);
    n_vec++; if (timed_out) begin n_bad++; $display("FAIL wd_bound: got 1 want 0"); end
    n_vec++; if (obs_len.size() != 1 || obs_len[0] != TIMEOUT) begin
      n_bad++; $display("FAIL wd_runlen: got %p want '{%0d}", obs_len, TIMEOUT);
    end
    n_vec++; if (err_timeout !== 1'b1 || busy !== 1'b0 || end_k != 18) begin
      n_bad++; $display("FAIL wd_err: got err=%b busy=%b k=%0d want 1/0/18",
                        err_timeout, busy, end_k);
    end
    n_vec++; if (fin_n != 0 || inst_count !== 5'd0) begin
      n_bad++; $display("FAIL wd_noretire: got fin=%0d cnt=%0d want 0/0", fin_n, inst_count);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (err_timeout !== 1'b1) begin
      n_bad++; $display("FAIL wd_sticky: got %b want 1", err_timeout);
    end
    cpu_en = 1'b1;
    mem[0] = 16'h6C01;
    exp_q.push_back(16'h6C01);
    do_start();
    observe(40, 0);
    n_vec++; if (err_first !== 1'b0 || err_timeout !== 1'b0 || timed_out) begin
      n_bad++; $display("FAIL wd_clear: got first=%b now=%b to=%0d want 0/0/0",
                        err_first, err_timeout, timed_out);
    end
    while (exp_q.size() > 0) begin
      got = (obs_inst.size() > 0) ? obs_inst.pop_front() : 16'hxxxx;
      n_vec++; if (got !== exp_q[0]) begin
        n_bad++; $display("FAIL wd_restart_inst: got %h want %h", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_vec++; if (obs_addr.size() != 1 || obs_addr[0] != 0 || inst_count !== 5'd1) begin
      n_bad++; $display("FAIL wd_restart: got %p cnt=%0d want '{0} cnt=1", obs_addr, inst_count);
    end
  endtask

  task automatic test_ignored_inputs();
    mem[0] = 16'h2405;
    do_start();
    observe(40, 4);
    n_vec++; if (obs_addr.size() != 1 || fin_k != 6 || end_k != 7 || timed_out) begin
      n_bad++; $display("FAIL start_in_issue: got fetches=%0d fin=%0d end=%0d want 1/6/7",
                        obs_addr.size(), fin_k, end_k);
    end
    cpu_en = 1'b0;
    done_force = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_vec++; if ({bus.mem_en, bus.run, busy, finished} !== 4'b0) begin
        n_bad++; $display("FAIL done_in_idle: got %b want 0000",
                          {bus.mem_en, bus.run, busy, finished});
      end
    end
    done_force = 1'b0;
    cpu_en = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [15:0] prog [3];
    prog[0] = 16'h2004; prog[1] = 16'h4408; prog[2] = 16'h6C01;
    for (int i = 0; i < 3; i++) mem[i] = prog[i];
    do_start();
    repeat (2) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    n_vec++; if ({bus.mem_en, bus.run, busy, finished, err_timeout} !== 5'b0) begin
      n_bad++; $display("FAIL async_ctrl: got %b want 00000",
                        {bus.mem_en, bus.run, busy, finished, err_timeout});
    end
    n_vec++; if (bus.d_inst !== 16'h0 || bus.mem_addr !== '0 || inst_count !== '0) begin
      n_bad++; $display("FAIL async_data: got %h/%h/%h want 0/0/0",
                        bus.d_inst, bus.mem_addr, inst_count);
    end
    #3 reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
    do_start();
    observe(80, 0);
    while (exp_q.size() > 0) begin
      got = (obs_inst.size() > 0) ? obs_inst.pop_front() : 16'hxxxx;
      n_vec++; if (got !== exp_q[0]) begin
        n_bad++; $display("FAIL async_rerun_inst: got %h want %h", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_vec++; if (obs_addr.size() != 3 || obs_addr[0] != 0 || inst_count !== 5'd3 || timed_out) begin
      n_bad++; $display("FAIL async_rerun: got %p cnt=%0d want '{0,1,2} cnt=3",
                        obs_addr, inst_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_end_of_mem();
    test_watchdog();
    test_ignored_inputs();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/inst_issuer.md
# inst_issuer

Instruction issuer that drives the CPU control FSM from the other side of its `run`/`d_inst`/`done` interface. On `start`, it fetches 16-bit instructions from a synchronous-read program memory and presents each one on `d_inst` with `run` high. It holds the instruction until the CPU asserts `done`, then retires it and advances the program counter. Sits between the program ROM/RAM and `cpu`; a `done` watchdog stops a hung program.

## Interface
- `ADDR_W`, default 4: program memory address width (2^ADDR_W instructions).
- `TIMEOUT`, default 15: maximum ISSUE cycles without `done` before a timeout error; legal range 4..255.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: reset is asynchronous and active-high.
- `start` in 1: begin a program at address 0; sampled only in IDLE or ERR.
- `mem_en` out 1: program memory read enable.
- `mem_addr` out ADDR_W: program memory read address.
- `mem_rdata` in 16: read data, valid the cycle after `mem_en`.
- `run` out 1: instruction valid to CPU.
- `d_inst` out 16: instruction to CPU; stable while `run`=1.
- `done` in 1: CPU completion, sampled while `run`=1.
- `busy` out 1: high in every state except IDLE and ERR.
- `finished` out 1: one-cycle pulse when a program ends normally.
- `err_timeout` out 1: sticky watchdog error.
- `inst_count` out ADDR_W+1: instructions retired in the current or last program.

## Operation
- Instruction fields match the CPU: [15:13] Rx, [12:10] Ry, [4:2] ALU op. Bit [0] is the LAST flag, which the CPU ignores.
- States: IDLE, FETCH, LOAD, ISSUE, RETIRE, ERR.
- IDLE: `start`=1 → `pc`←0, `inst_count`←0, `err_timeout` unchanged (0 after reset) → FETCH.
- FETCH: `mem_en`=1, `mem_addr`=`pc` → LOAD.
- LOAD: `ir`←`mem_rdata`, watchdog←0 → ISSUE.
- ISSUE:
  - `run`=1, `d_inst`=`ir`.
  - `done`=1 → RETIRE.
  - Otherwise watchdog+1. When the watchdog reaches TIMEOUT-1 with no `done` → ERR.
- RETIRE:
  - `run`=0, `inst_count`+1.
  - If `ir`[0]=1 or `pc`=2^ADDR_W-1: `finished`=1 → IDLE. End of memory is an implicit halt; there is no wrap-around.
  - Else `pc`+1 → FETCH.
- ERR: `run`=0, `err_timeout`=1. `start`=1 clears `err_timeout` and restarts exactly as from IDLE.
- `start` in FETCH/LOAD/ISSUE/RETIRE is ignored.
- `done` outside ISSUE is ignored.
- `done` on the same cycle the watchdog expires: `done` wins → RETIRE.
- `d_inst` outside ISSUE holds the last `ir`; it is 0 after reset.
- `inst_count` saturates at 2^ADDR_W and holds its value in IDLE/ERR until the next `start`.

## Timing
- Reset values: state IDLE; `pc`, `ir`, watchdog, `inst_count` = 0; all outputs 0.
- Reset mid-program: `run`, `mem_en` and `busy` drop asynchronously; no `finished` pulse.
- `start` sampled high at edge N: `mem_en`=1 in cycle N+1, `run`=1 from cycle N+3.
- With the CPU (done on its third run cycle), each instruction takes 6 cycles: FETCH, LOAD, 3×ISSUE, RETIRE. Back-to-back instructions have `run` low for exactly 3 cycles between them.
- `finished` is high in the RETIRE cycle of the last instruction. `busy` falls one cycle later.
- Timeout: `run` high for exactly TIMEOUT cycles, then `err_timeout`=1 from the next cycle.
- All outputs are registered or decoded from state only; there is no combinational path from `done` or `start` to any output.

## Structure
- `issuer_pkg`:
  - `issuer_state_t` enum.
  - Field constants `RX_HI`/`RX_LO`, `RY_HI`/`RY_LO`, `OP_HI`/`OP_LO`, `LAST_BIT`=0.
  - `INST_W`=16.
- Sub-module `issue_watchdog`: counter with clear/enable, TIMEOUT parameter, `expired` output. Instantiated once.
- `inst_issuer` holds the FSM, `pc`, `ir` and `inst_count`.

## Test plan
- Single instruction 0x2405 at address 0, CPU model done on 3rd run cycle:
  - `start` → `d_inst`=0x2405 with `run` high for 3 cycles.
  - `finished` pulse at cycle 6; `inst_count`=1.
- Program 0x2004, 0x4408, 0x6C01:
  - Three issues in order, `run` gaps of 3 cycles.
  - `finished` after the third; `inst_count`=3; `mem_addr` sequence 0,1,2.
- Memory of 16 words with no LAST flag: program halts after address 15; `inst_count`=16; `mem_addr` never returns to 0.
- Watchdog, CPU never asserts `done`, TIMEOUT=15:
  - `run` high for exactly 15 cycles, then `err_timeout`=1, `busy`=0.
  - `start` clears the error and restarts at address 0.
- `start` pulsed during ISSUE and `done` pulsed in IDLE: no state change, no extra `mem_en`.
- Asynchronous `reset` asserted mid-ISSUE (off clock edge): `run`=0 immediately, all outputs 0. A subsequent `start` runs the program from address 0 correctly.
